// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, data segment base and
// default RAM depth.
package mem_arb_pkg;

    // Identifies which master owned the RAM on the last granted cycle.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [31:0] DATA_BASE_ADDR    = 32'h1001_0000;
    localparam int unsigned DEFAULT_MEM_DEPTH = 256;

endpackage

// File: rtl/arb_rr2.sv
// Two-request round-robin picker. Bit 0 is the CPU, bit 1 is the debug port.
// When both request, the one that did not own the RAM last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    output logic [1:0] grant_o
);

    // Single requester wins outright; contention goes to the non-last owner.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_owner_i == OWN_DBG) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and a debug/loader port.
// One owner per cycle, two-way round-robin; the CPU is stalled while it loses.
// Optional feature: define MEM_ARB_ERR_EN to suppress out-of-range or misaligned accesses
// and raise a sticky err_o.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DATA_BASE_ADDR),
    parameter int unsigned           MEM_DEPTH  = DEFAULT_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    output logic                  dbg_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);

    owner_e                last_owner_q, last_owner_d;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic [1:0]            grant;
    logic                  cpu_grant, dbg_grant, any_grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_offset;
    logic                  access_bad;

    arb_rr2 u_arb_rr2 (
        .req_i       ({dbg_req_i, cpu_req_i}),
        .last_owner_i(last_owner_q),
        .grant_o     (grant)
    );

    assign cpu_grant = grant[0];
    assign dbg_grant = grant[1];
    assign any_grant = cpu_grant | dbg_grant;

    // Route the granted master's address, data and direction to the RAM.
    always_comb begin
        sel_we      = cpu_we_i;
        sel_offset  = cpu_addr_i - BASE_ADDR;
        mem_wdata_o = cpu_wdata_i;
        if (dbg_grant) begin
            sel_we      = dbg_we_i;
            sel_offset  = dbg_addr_i - BASE_ADDR;
            mem_wdata_o = dbg_wdata_i;
        end
    end

    assign mem_addr_o = sel_offset;

`ifdef MEM_ARB_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] RangeLimit = ADDR_WIDTH'(MEM_DEPTH * 4);

    logic err_q;

    // Out-of-range or non-word-aligned accesses are acknowledged but never reach the RAM.
    always_comb begin
        access_bad = any_grant && ((sel_offset >= RangeLimit) || (sel_offset[1:0] != 2'b00));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (access_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign access_bad = 1'b0;
    assign err_o      = 1'b0;
`endif

    // Strobes are also gated by reset so nothing is issued while it is held low.
    always_comb begin
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        if (any_grant && !access_bad && reset) begin
            mem_write_o = sel_we;
            mem_read_o  = ~sel_we;
        end
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_grant;
    assign cpu_rdata_o = (cpu_grant && access_bad) ? '0 : mem_rdata_i;

    // Ownership only moves on a granted cycle; idle cycles keep the history.
    always_comb begin
        last_owner_d = last_owner_q;
        if (dbg_grant) begin
            last_owner_d = OWN_DBG;
        end else if (cpu_grant) begin
            last_owner_d = OWN_CPU;
        end
    end

    // Arbitration history and the debug ack/read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= OWN_DBG;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            dbg_ack_q    <= dbg_grant;
            if (dbg_grant && !dbg_we_i) begin
                dbg_rdata_q <= access_bad ? '0 : mem_rdata_i;
            end
        end
    end

    assign dbg_ack_o   = dbg_ack_q;
    assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural RAM behind it.
// Define MEM_ARB_ERR_EN for both bench and RTL to exercise the range-error build.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
    logic        dbg_ack_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_write_o, mem_read_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];

    data_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .dbg_req_i  (dbg_req_i),
        .dbg_we_i   (dbg_we_i),
        .dbg_addr_i (dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i),
        .dbg_rdata_o(dbg_rdata_o),
        .dbg_ack_o  (dbg_ack_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_write_o(mem_write_o),
        .mem_read_o (mem_read_o),
        .mem_rdata_i(mem_rdata_i),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on the rising edge.
    assign mem_rdata_i = (mem_addr_o < 32'd1024) ? ram[mem_addr_o[9:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_write_o && mem_addr_o < 32'd1024) ram[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    task automatic idle_inputs();
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h1001_0000;
        cpu_wdata_i = 32'h0;
        dbg_req_i   = 1'b0;
        dbg_we_i    = 1'b0;
        dbg_addr_i  = 32'h1001_0000;
        dbg_wdata_i = 32'h0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        cpu_req_i = 1'b1;
        cpu_we_i  = 1'b1;
        #1;
        checks++;
        if (mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe: wr=%b rd=%b expected 0 0", mem_write_o, mem_read_o);
        end
        checks++;
        if (dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ack=%b rdata=%h err=%b expected 0 0 0",
                     dbg_ack_o, dbg_rdata_o, err_o);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (mem_write_o !== 1'b0 || mem_read_o !== 1'b0 || dbg_ack_o !== 1'b0 ||
            cpu_stall_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle: wr=%b rd=%b ack=%b stall=%b err=%b expected all 0",
                     mem_write_o, mem_read_o, dbg_ack_o, cpu_stall_o, err_o);
        end
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b1;
        cpu_addr_i  = 32'h1001_0008;
        cpu_wdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (mem_addr_o !== 32'h8 || mem_write_o !== 1'b1 || mem_read_o !== 1'b0 ||
            mem_wdata_o !== 32'hDEAD_BEEF || cpu_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL cpu_store: addr=%h wr=%b rd=%b wdata=%h stall=%b expected 8 1 0 deadbeef 0",
                     mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o, cpu_stall_o);
        end
        @(negedge clk);
        cpu_we_i = 1'b0;
        #1;
        checks++;
        if (mem_addr_o !== 32'h8 || mem_read_o !== 1'b1 || mem_write_o !== 1'b0 ||
            cpu_rdata_o !== 32'hDEAD_BEEF || cpu_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load: addr=%h rd=%b wr=%b rdata=%h stall=%b expected 8 1 0 deadbeef 0",
                     mem_addr_o, mem_read_o, mem_write_o, cpu_rdata_o, cpu_stall_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_dbg_only();
        @(negedge clk);
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'b1;
        dbg_addr_i  = 32'h1001_0010;
        dbg_wdata_i = 32'h1234_5678;
        #1;
        checks++;
        if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_wdata_o !== 32'h1234_5678 ||
            dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_write: wr=%b addr=%h wdata=%h ack=%b expected 1 10 12345678 0",
                     mem_write_o, mem_addr_o, mem_wdata_o, dbg_ack_o);
        end
        @(negedge clk);
        // Ack cycle: master switches to a read, which counts as a new request.
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL dbg_write_ack: ack=%b rdata=%h expected 1 0", dbg_ack_o, dbg_rdata_o);
        end
        dbg_we_i = 1'b0;
        #1;
        checks++;
        if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL dbg_read: rd=%b addr=%h expected 1 10", mem_read_o, mem_addr_o);
        end
        @(negedge clk);
        dbg_req_i = 1'b0;
        #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dbg_read_ack: ack=%b rdata=%h expected 1 12345678",
                     dbg_ack_o, dbg_rdata_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dbg_ack_single: ack=%b rdata=%h expected 0 12345678",
                     dbg_ack_o, dbg_rdata_o);
        end
    endtask

    task automatic test_contention_after_reset();
        pulse_reset();
        // Both in the same cycle: CPU loads 0x8, debug writes 0x8.
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h1001_0008;
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'b1;
        dbg_addr_i  = 32'h1001_0008;
        dbg_wdata_i = 32'hCAFE_F00D;
        #1;
        checks++;
        if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || cpu_stall_o !== 1'b0 ||
            cpu_rdata_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL contend_cpu_first: rd=%b wr=%b stall=%b rdata=%h expected 1 0 0 deadbeef",
                     mem_read_o, mem_write_o, cpu_stall_o, cpu_rdata_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_write_o !== 1'b1 || cpu_stall_o !== 1'b1 || mem_wdata_o !== 32'hCAFE_F00D ||
            dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL contend_dbg_second: wr=%b stall=%b wdata=%h ack=%b expected 1 1 cafef00d 0",
                     mem_write_o, cpu_stall_o, mem_wdata_o, dbg_ack_o);
        end
        @(negedge clk);
        dbg_req_i = 1'b0;
        #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || cpu_stall_o !== 1'b0 || mem_read_o !== 1'b1 ||
            cpu_rdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL contend_loser_sees_write: ack=%b stall=%b rd=%b rdata=%h expected 1 0 1 cafef00d",
                     dbg_ack_o, cpu_stall_o, mem_read_o, cpu_rdata_o);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_dbg;
        pulse_reset();
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h1001_0020;
        dbg_req_i  = 1'b1;
        dbg_we_i   = 1'b0;
        dbg_addr_i = 32'h1001_0040;
        for (int i = 0; i < 6; i++) begin
            exp_dbg = (i % 2) == 1;
            #1;
            checks++;
            if (cpu_stall_o !== exp_dbg || mem_addr_o !== (exp_dbg ? 32'h40 : 32'h20) ||
                dbg_ack_o !== (i > 0 && !exp_dbg)) begin
                errors++;
                $display("FAIL alternate[%0d]: stall=%b addr=%h ack=%b expected %b %h %b", i,
                         cpu_stall_o, mem_addr_o, dbg_ack_o, exp_dbg,
                         exp_dbg ? 32'h40 : 32'h20, (i > 0 && !exp_dbg));
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++;
        if (dbg_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL alternate_last_ack: ack=%b expected 1", dbg_ack_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dbg_req_i = 1'b1;
        dbg_we_i  = 1'b0;
        @(negedge clk);
        dbg_req_i = 1'b0;
        reset     = 1'b0;
        #1;
        checks++;
        if (dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_discards_ack: ack=%b expected 0", dbg_ack_o);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_range();
        @(negedge clk);
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b1;
        cpu_addr_i  = 32'h1001_0400;
        cpu_wdata_i = 32'h5555_AAAA;
        #1;
`ifdef MEM_ARB_ERR_EN
        checks++;
        if (mem_write_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL range_suppress: wr=%b stall=%b expected 0 0", mem_write_o, cpu_stall_o);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL range_err_set: err=%b expected 1", err_o);
        end
        // Misaligned debug read: acknowledged, data forced to 0.
        dbg_req_i  = 1'b1;
        dbg_addr_i = 32'h1001_0011;
        #1;
        checks++;
        if (mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_suppress: rd=%b expected 0", mem_read_o);
        end
        @(negedge clk);
        dbg_req_i = 1'b0;
        #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_ack: ack=%b rdata=%h err=%b expected 1 0 1",
                     dbg_ack_o, dbg_rdata_o, err_o);
        end
        pulse_reset();
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL range_err_clear: err=%b expected 0", err_o);
        end
`else
        checks++;
        if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h400 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL range_unchecked: wr=%b addr=%h err=%b expected 1 400 0",
                     mem_write_o, mem_addr_o, err_o);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_tied_low: err=%b expected 0", err_o);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        test_reset();
        test_cpu_only();
        test_dbg_only();
        test_contention_after_reset();
        test_back_to_back();
        test_reset_mid();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
